// File: rtl/instr_fetch_unit_if.sv
// Purpose : instruction-memory read port of the fetch unit (req/ack word read).
// Latency : combinational bundle, no storage.
// Backpr. : request is held until ack; the memory side stalls by withholding mem_ack.
//
// Signals:
//   mem_req   fetch unit -> memory   read request, held until mem_ack
//   mem_addr  fetch unit -> memory   word address, stable while mem_req=1
//   mem_ack   memory -> fetch unit   mem_rdata is valid this cycle
//   mem_rdata memory -> fetch unit   instruction word
interface instr_fetch_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Purpose : fetch sequencer; reads the word at PC_in, loads IR_out, pulses pc_inc.
// Latency : 2 edges fetch_go->ir_valid with zero-wait memory; 3-cycle minimum cadence.
// Backpr. : mem_req held until mem_ack or TIMEOUT REQ cycles; fetch_go ignored while busy.
//
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   PC_in             current program counter value
//   fetch_go          control-unit fetch request (level, sampled in IDLE)
//   redirect          PC load pulse; aborts/discards any in-flight fetch
//   mem               instruction memory read port (master side)
//   IR_out            instruction register
//   ir_valid, pc_inc  coincident one-cycle pulses on a successful fetch
//   busy              high while a request is outstanding
//   fetch_err         sticky: misaligned PC or timeout; cleared by next aligned fetch
module instr_fetch_unit #(
  parameter int TIMEOUT = 16  // REQ cycles without ack before abandoning; 2..255
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [31:0]               PC_in,
  input  logic                      fetch_go,
  input  logic                      redirect,
  instr_fetch_unit_if.master        mem,
  output logic [31:0]               IR_out,
  output logic                      ir_valid,
  output logic                      pc_inc,
  output logic                      busy,
  output logic                      fetch_err
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t           state_q,    state_d;
  logic             mem_req_q,  mem_req_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      ir_q,       ir_d;
  logic             ir_valid_q, ir_valid_d;
  logic             pc_inc_q,   pc_inc_d;
  logic             busy_q,     busy_d;
  logic             err_q,      err_d;
  logic             discard_q,  discard_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0;
      ir_q       <= 32'h0;
      ir_valid_q <= 1'b0;
      pc_inc_q   <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      discard_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      pc_inc_q   <= pc_inc_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      discard_q  <= discard_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    ir_d       = ir_q;
    ir_valid_d = 1'b0;
    pc_inc_d   = 1'b0;
    err_d      = err_q;
    discard_d  = discard_q;
    cnt_d      = cnt_q;

    case (state_q)
      ST_IDLE: begin
        // A redirect makes PC_in stale, and during the pc_inc cycle the PC has
        // not advanced yet; either way this cycle's fetch_go must be dropped.
        // A late mem_ack seen here (e.g. after reset) is simply ignored.
        if (fetch_go && !redirect && !pc_inc_q) begin
          if (PC_in[1:0] != 2'b00) begin
            err_d = 1'b1;
          end else begin
            err_d      = 1'b0;
            mem_addr_d = PC_in;
            mem_req_d  = 1'b1;
            cnt_d      = '0;
            discard_d  = 1'b0;
            state_d    = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        if (mem.mem_ack) begin
          // An ack in the final timeout cycle still completes normally.
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
          if (!discard_q && !redirect) begin
            ir_d       = mem.mem_rdata;
            ir_valid_d = 1'b1;
            pc_inc_d   = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // The request cannot be withdrawn, so a redirect only marks the
          // eventual return data as stale.
          if (redirect) begin
            discard_d = 1'b1;
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d == ST_REQ);
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign IR_out       = ir_q;
  assign ir_valid     = ir_valid_q;
  assign pc_inc       = pc_inc_q;
  assign busy         = busy_q;
  assign fetch_err    = err_q;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch sequencer on the consumer side of the program counter. It takes the current PC value, issues a word read to instruction memory over a req/ack handshake, and latches the returned word into the instruction register. It then pulses `pc_inc` back to the program counter to advance it by 4. It sits between the control unit, which requests fetches, the program counter, and instruction memory, and it handles PC redirects, misalignment and memory timeout.

## Interface
- `TIMEOUT`, default 16: number of REQ cycles without `mem_ack` before the fetch is abandoned; legal range 2..255.
- `CLK`  in  1  system clock; all state changes on its rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `PC_in`  in  32  current PC from the program counter.
- `fetch_go`  in  1  control-unit request for one fetch; level sampled each edge.
- `redirect`  in  1  one-cycle pulse, asserted in the same cycle the program counter is loaded (`pc_ld`); aborts any in-flight fetch.
- `mem_req`  out  1  read request to instruction memory.
- `mem_addr`  out  32  word address of the read; stable while `mem_req`=1.
- `mem_ack`  in  1  memory has put valid data on `mem_rdata` this cycle.
- `mem_rdata`  in  32  instruction word.
- `IR_out`  out  32  instruction register.
- `ir_valid`  out  1  one-cycle pulse: `IR_out` was just updated.
- `pc_inc`  out  1  one-cycle pulse to the program counter increment input.
- `busy`  out  1  a fetch is in progress (state REQ).
- `fetch_err`  out  1  sticky error flag: misaligned PC or timeout.

## Operation
- Two-state FSM: IDLE and REQ. All outputs are registered.
- Reset values:
  - state = IDLE.
  - `mem_req`, `ir_valid`, `pc_inc`, `busy`, `fetch_err` = 0.
  - `mem_addr` = 32'h0, `IR_out` = 32'h0.
  - Discard flag and timeout counter = 0.
- IDLE, when `fetch_go`=1 is accepted:
  - Misaligned (`PC_in[1:0]` != 0): set `fetch_err`=1 and remain in IDLE. No request is issued.
  - Aligned: clear `fetch_err`, set `mem_addr`<=`PC_in` and `mem_req`<=1, clear the counter and discard flag, go to REQ.
- IDLE, `fetch_go` is ignored when either of these holds:
  - `redirect`=1 in the same cycle (redirect has priority; `PC_in` is stale).
  - `pc_inc`=1 that cycle (PC not yet advanced).
- REQ:
  - `mem_req` is held at 1 and `mem_addr` is held constant until `mem_ack`. The request is never withdrawn early except on timeout or reset.
  - `fetch_go` is ignored.
- REQ, `redirect`=1 without `mem_ack`: set the discard flag and stay in REQ until the ack arrives.
- REQ, `mem_ack`=1:
  - Drop `mem_req` and go to IDLE.
  - If the discard flag is clear and `redirect` is 0 this cycle: `IR_out`<=`mem_rdata`, and `ir_valid` and `pc_inc` pulse for one cycle.
  - Otherwise the data is dropped; `IR_out` is unchanged and neither pulse fires.
- Timeout:
  - The counter increments on each REQ cycle without `mem_ack`.
  - When it reaches `TIMEOUT`-1 with no ack: drop `mem_req`, set `fetch_err`=1, go to IDLE. No `ir_valid` or `pc_inc`.
  - An ack arriving in that same cycle wins; it is treated as a normal completion.
- `fetch_err` stays at 1 until the next accepted aligned `fetch_go`, or until reset.
- `busy` = 1 exactly while the state is REQ.
- Reset mid-fetch: `mem_req` falls after the reset edge. A late `mem_ack` arriving in IDLE is ignored.

## Timing
- Edge 0 samples `fetch_go` in IDLE. From cycle 1: `mem_req`=1, `mem_addr`=PC, `busy`=1.
- `mem_ack` sampled at edge k, with k≥1:
  - During cycle k+1: `IR_out` holds the new word, `ir_valid`=1, `pc_inc`=1, `mem_req`=0, `busy`=0.
- The program counter advances at edge k+1.
- The earliest next accepted `fetch_go` is at edge k+2, so the minimum cadence is 3 cycles per fetch with zero-wait memory.
- Minimum latency from `fetch_go` to `ir_valid` is 2 edges.
- Timeout: with no ack, `mem_req` is high for exactly `TIMEOUT` cycles. `fetch_err` rises in the cycle after the last one.
- `ir_valid` and `pc_inc` are always coincident single-cycle pulses.

## Test plan
- Zero-wait fetch:
  - Stimulus: PC_in=32'h0000_0010, fetch_go pulse, mem_ack in the first REQ cycle with rdata=32'h8C22_0004.
  - Required: mem_addr=32'h10; IR_out=32'h8C22_0004 with ir_valid=pc_inc=1 for one cycle, 2 edges after fetch_go.
- Wait states and back-to-back:
  - Stimulus: ack after 3 REQ cycles; fetch_go held high throughout.
  - Required: fetch_go ignored during busy and during the pc_inc cycle; the second request appears with the incremented PC (PC_in+4) at mem_addr.
- Redirect mid-fetch:
  - Stimulus: redirect pulse in REQ, then ack 2 cycles later.
  - Required: mem_req held until the ack; no ir_valid or pc_inc; IR_out unchanged.
  - Repeat with redirect and ack in the same cycle; same required response.
- Misalignment:
  - Stimulus: PC_in=32'h0000_0006, fetch_go.
  - Required: fetch_err=1, mem_req never asserts.
  - Then an aligned fetch_go clears fetch_err.
- Timeout (TIMEOUT=16):
  - Stimulus: never ack.
  - Required: mem_req high for exactly 16 cycles, then 0; fetch_err=1; no pc_inc.
  - Repeat with the ack in the 16th cycle: normal completion, fetch_err=0.
- Reset in REQ:
  - Stimulus: assert RESET during REQ.
  - Required: next cycle all outputs are 0 and state is IDLE; a stray mem_ack afterwards produces no ir_valid.
